dbus_arbiter: RTL and testbench
===============================

# dbus_arbiter

Two-requester arbiter for the single system data bus: it shares the downstream `master_bus_if` between the core load/store port and the debug module's system-bus-access port. Each requester issues one-cycle `bstart` pulses; the arbiter latches the request, serialises transactions with round-robin fairness, and routes `bdone`/`rdata` back to the owner. It sits between the core/DM and the bus interconnect.

## Interface
- `DM_PRIO_WHEN_HALTED`, 1: when 1 and `halted`=1, the DM wins every contention regardless of the round-robin pointer.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `halted`  in  1  core halted indication, also used by the DM.
- `core`  `master_bus_if.slave`  -  core requester (`bstart`, `breq`, `ttype`, `addr`, `wdata`, `tsize` in; `bdone`, `rdata` out).
- `dm`  `master_bus_if.slave`  -  debug module requester, same signals.
- `bus`  `master_bus_if.master`  -  downstream bus.
- `proto_err`  out  1  sticky; set when a requester pulses `bstart` while its own request is pending or in flight. Cleared only by reset.

## Operation
- Per requester, a pending slot holds `ttype`, `addr`, `wdata`, `tsize` and a valid bit, captured on the cycle that requester's `bstart`=1.
- FSM `arb_state_e`:
  - `GIDLE`: no owner.
  - `GCORE`/`GDM`: transaction in flight for that owner.
- `GIDLE`:
  - If any pending slot is valid (including one captured this cycle), go to the chosen owner's state. The launch is registered.
  - Choice rule: a single valid slot wins. If both are valid, the DM wins when `DM_PRIO_WHEN_HALTED`=1 and `halted`=1. Otherwise the requester not granted last wins.
  - `last_grant` resets to core, so the DM wins the first tie.
- Entering `GCORE`/`GDM`:
  - Downstream `bstart`=`breq`=1 for exactly the first cycle in the state.
  - Downstream `ttype`/`addr`/`wdata`/`tsize` are driven from the owner's slot for the whole state.
  - The owner's valid bit clears on entry.
  - `last_grant` updates on entry.
- `GCORE`/`GDM` while downstream `bdone`=0: stay.
- `GCORE`/`GDM` on downstream `bdone`=1:
  - Owner `bdone`=1 that cycle. Owner `rdata` = `bus.rdata` in that cycle (combinational).
  - If the other slot is valid, go directly to the other owner's state (back-to-back, no idle cycle). Otherwise go to `GIDLE`.
- While in `GCORE`, the core slot is empty and may capture a new request; the same applies to the DM in `GDM`. That request is not re-granted ahead of a valid other slot.
- Non-owner `bdone` is always 0. Non-owner `rdata` holds the last value returned to it (registered copy).
- Requester `bstart` while its own slot is valid or it is the owner: the new request is ignored and `proto_err` is set.
- Outputs at reset:
  - FSM `GIDLE`, slots invalid, `last_grant`=core.
  - All downstream controls 0, `ttype`=READ, `tsize`=WORD.
  - Both requester `bdone`=0 and `rdata`=0; `proto_err`=0.
- Reset mid-transaction aborts silently: no `bdone` is ever returned for the aborted request.

## Timing
- Requester `bstart` at cycle N with the arbiter idle: downstream `bstart` at N+1.
  - Earliest requester `bdone` is N+1, when the bus completes in the start cycle.
- Contended request: downstream `bstart` in the cycle after the owner's `bdone`.
- Downstream `bdone` in the same cycle as the downstream `bstart` is legal and completes the grant.
- Simultaneous core and DM `bstart` in `GIDLE`: one launch at N+1; the other launches the cycle after the first `bdone`.
- Downstream fields are stable from `bstart` through `bdone` inclusive.

## Structure
- `arb_state_e` and the `requester_e` {REQ_CORE, REQ_DM} enum go in `bus_if_types_pkg`, next to the `READ`/`WRITE` and `WORD` types.
- One sub-module, `bus_req_slot`: capture register plus valid bit, instantiated once per requester.
- Everything else lives in the top: FSM, round-robin pointer, output muxing.

## Test plan
- **Single core read:** core `bstart` with `addr`=0x1000 at N; bus returns `rdata`=0xDEADBEEF with `bdone` at N+3 -> downstream `bstart` at N+1 only, core `bdone`=1 and core `rdata`=0xDEADBEEF at N+3, dm `bdone`=0 throughout.
- **Simultaneous after reset:** core and DM `bstart` together, `halted`=0 -> DM launches first. Next tie -> core launches first.
- **Halted priority:** `halted`=1, `DM_PRIO_WHEN_HALTED`=1, both request together twice -> the DM wins both times.
- **Queued write:** DM write `wdata`=0x12345678 issued while a core read is in flight -> DM transaction launches the cycle after the core `bdone` with `wdata`=0x12345678 and `ttype`=WRITE; no idle cycle between.
- **Same-cycle completion:** bus asserts `bdone` in its `bstart` cycle -> requester `bdone` at N+1; FSM returns to `GIDLE` at N+2.
- **Protocol error and reset abort:**
  - A second core `bstart` while the core is in flight -> `proto_err`=1; the ignored request never appears downstream.
  - Assert `rst_n`=0 mid-transaction -> all outputs return to reset values immediately, and no `bdone` follows after release.

Source files
------------

// File: rtl/bus_if_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_if_types_pkg - shared data-bus types and arbiter encodings    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package bus_if_types_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_e;
  typedef enum logic [1:0] {BYTE = 2'b00, HALF = 2'b01, WORD = 2'b10} tsize_e;
  typedef enum logic {REQ_CORE = 1'b0, REQ_DM = 1'b1} requester_e;
  typedef enum logic [1:0] {GIDLE = 2'b00, GCORE = 2'b01, GDM = 2'b10} arb_state_e;

  typedef struct packed {
    ttype_e              ttype;
    tsize_e              tsize;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   wdata;
  } bus_req_t;
endpackage
`default_nettype wire

// File: rtl/master_bus_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | master_bus_if - single-beat pulse-started data bus                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface master_bus_if;
  logic                                     bstart;
  logic                                     breq;
  bus_if_types_pkg::ttype_e                 ttype;
  logic [bus_if_types_pkg::ADDR_W-1:0]      addr;
  logic [bus_if_types_pkg::DATA_W-1:0]      wdata;
  bus_if_types_pkg::tsize_e                 tsize;
  logic                                     bdone;
  logic [bus_if_types_pkg::DATA_W-1:0]      rdata;

  modport master (output bstart, breq, ttype, addr, wdata, tsize,
                  input  bdone, rdata);
  modport slave  (input  bstart, breq, ttype, addr, wdata, tsize,
                  output bdone, rdata);
endinterface
`default_nettype wire

// File: rtl/bus_req_slot.sv
`default_nettype none
// +------------------------------------------------------------------+
// | bus_req_slot - one pending request register with valid bit        |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module bus_req_slot
  import bus_if_types_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     capture,
  input  logic     grant,
  input  bus_req_t req_in,
  output logic     valid,
  output bus_req_t req
);

  // A grant in the capture cycle launches straight from the fresh data,
  // so the valid bit never rises for it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      req.ttype <= READ;
      req.tsize <= WORD;
      req.addr  <= '0;
      req.wdata <= '0;
    end else begin
      if (capture) req <= req_in;
      if (grant)        valid <= 1'b0;
      else if (capture) valid <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dbus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dbus_arbiter - round-robin core/DM arbiter for the data bus       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module dbus_arbiter
  import bus_if_types_pkg::*;
#(
  parameter bit DM_PRIO_WHEN_HALTED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halted,
  master_bus_if.slave  core,
  master_bus_if.slave  dm,
  master_bus_if.master bus,
  output logic        proto_err
);

  arb_state_e state, state_nxt;
  requester_e last_grant;
  logic       launch;
  logic       core_own, dm_own, core_busy, dm_busy;
  logic       core_cap, dm_cap, core_err, dm_err;
  logic       core_valid, dm_valid, core_grant, dm_grant;
  logic       core_done, dm_done, pick_dm;
  bus_req_t   core_in, dm_in, core_req, dm_req, sel;
  logic [DATA_W-1:0] core_rdata_q, dm_rdata_q;
  logic       unused_breq;

  // breq is redundant with bstart on the requester side
  assign unused_breq = core.breq ^ dm.breq;

  assign core_own  = (state == GCORE);
  assign dm_own    = (state == GDM);
  assign core_busy = core_own && !bus.bdone;
  assign dm_busy   = dm_own && !bus.bdone;
  assign core_err  = core.bstart && (core_valid || core_busy);
  assign dm_err    = dm.bstart && (dm_valid || dm_busy);
  assign core_cap  = core.bstart && !core_valid && !core_busy;
  assign dm_cap    = dm.bstart && !dm_valid && !dm_busy;
  assign core_grant = (state_nxt == GCORE) && !core_own;
  assign dm_grant   = (state_nxt == GDM) && !dm_own;

  assign core_in = '{ttype: core.ttype, tsize: core.tsize, addr: core.addr, wdata: core.wdata};
  assign dm_in   = '{ttype: dm.ttype, tsize: dm.tsize, addr: dm.addr, wdata: dm.wdata};

  bus_req_slot u_core_slot (
    .clk(clk), .rst_n(rst_n), .capture(core_cap), .grant(core_grant),
    .req_in(core_in), .valid(core_valid), .req(core_req)
  );

  bus_req_slot u_dm_slot (
    .clk(clk), .rst_n(rst_n), .capture(dm_cap), .grant(dm_grant),
    .req_in(dm_in), .valid(dm_valid), .req(dm_req)
  );

  always_comb begin
    state_nxt = state;
    pick_dm   = 1'b0;
    if ((dm_valid || dm_cap) &&
        (!(core_valid || core_cap) || (DM_PRIO_WHEN_HALTED && halted) ||
         last_grant == REQ_CORE))
      pick_dm = 1'b1;
    case (state)
      GIDLE: if (core_valid || core_cap || dm_valid || dm_cap)
               state_nxt = pick_dm ? GDM : GCORE;
      GCORE: if (bus.bdone) state_nxt = dm_valid ? GDM : GIDLE;
      GDM:   if (bus.bdone) state_nxt = core_valid ? GCORE : GIDLE;
      default: state_nxt = GIDLE;
    endcase
  end

  assign core_done = core_own && bus.bdone;
  assign dm_done   = dm_own && bus.bdone;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= GIDLE;
      last_grant   <= REQ_CORE;
      launch       <= 1'b0;
      proto_err    <= 1'b0;
      core_rdata_q <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state  <= state_nxt;
      launch <= core_grant || dm_grant;
      if (core_grant)    last_grant <= REQ_CORE;
      else if (dm_grant) last_grant <= REQ_DM;
      if (core_err || dm_err) proto_err <= 1'b1;
      if (core_done) core_rdata_q <= bus.rdata;
      if (dm_done)   dm_rdata_q   <= bus.rdata;
    end
  end

  always_comb begin
    sel.ttype = READ;
    sel.tsize = WORD;
    sel.addr  = '0;
    sel.wdata = '0;
    if (core_own)    sel = core_req;
    else if (dm_own) sel = dm_req;
  end

  assign bus.bstart = launch;
  assign bus.breq   = launch;
  assign bus.ttype  = sel.ttype;
  assign bus.tsize  = sel.tsize;
  assign bus.addr   = sel.addr;
  assign bus.wdata  = sel.wdata;

  assign core.bdone = core_done;
  assign dm.bdone   = dm_done;
  assign core.rdata = core_done ? bus.rdata : core_rdata_q;
  assign dm.rdata   = dm_done ? bus.rdata : dm_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dbus_arbiter - directed self-checking bench for dbus_arbiter   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_dbus_arbiter;
  import bus_if_types_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic halted;
  logic proto_err;
  int   n_cmp;
  int   n_bad;

  master_bus_if core_if();
  master_bus_if dm_if();
  master_bus_if bus_if();

  dbus_arbiter #(.DM_PRIO_WHEN_HALTED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .halted(halted),
    .core(core_if), .dm(dm_if), .bus(bus_if), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; pulses last one cycle.
  task automatic next();
    @(posedge clk);
    #1;
    core_if.bstart = 1'b0; core_if.breq = 1'b0;
    dm_if.bstart   = 1'b0; dm_if.breq   = 1'b0;
    bus_if.bdone   = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic req(input bit is_dm, input logic [31:0] a, input ttype_e t, input logic [31:0] wd);
    if (is_dm) begin
      dm_if.bstart = 1'b1; dm_if.breq = 1'b1; dm_if.addr = a;
      dm_if.ttype = t; dm_if.wdata = wd; dm_if.tsize = WORD;
    end else begin
      core_if.bstart = 1'b1; core_if.breq = 1'b1; core_if.addr = a;
      core_if.ttype = t; core_if.wdata = wd; core_if.tsize = WORD;
    end
  endtask

  // Lone request completed by the bus in its own start cycle.
  task automatic single(input bit is_dm, input logic [31:0] a, input string tag);
    next(); req(is_dm, a, READ, 32'h0); mid();
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'h55; mid();
    chk({tag, "_launch"}, {bus_if.bstart, bus_if.addr}, {1'b1, a});
    chk({tag, "_done"}, is_dm ? dm_if.bdone : core_if.bdone, 1'b1);
    chk({tag, "_other"}, is_dm ? core_if.bdone : dm_if.bdone, 1'b0);
    chk({tag, "_own_st"}, dut.state, is_dm ? GDM : GCORE);
    next(); mid();
    chk({tag, "_idle_st"}, dut.state, GIDLE);
    chk({tag, "_idle_bs"}, bus_if.bstart, 1'b0);
  endtask

  // Core (0x2000) and DM (0x3000) request together; each completes in one cycle.
  task automatic tie(input bit dm_first, input string tag);
    logic [31:0] a1, a2;
    a1 = dm_first ? 32'h3000 : 32'h2000;
    a2 = dm_first ? 32'h2000 : 32'h3000;
    next(); req(1'b0, 32'h2000, READ, 32'h0); req(1'b1, 32'h3000, READ, 32'h0); mid();
    chk({tag, "_nolaunch"}, bus_if.bstart, 1'b0);
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'hA1; mid();
    chk({tag, "_first"}, {bus_if.bstart, bus_if.addr}, {1'b1, a1});
    chk({tag, "_first_done"}, dm_first ? dm_if.bdone : core_if.bdone, 1'b1);
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'hA2; mid();
    chk({tag, "_second"}, {bus_if.bstart, bus_if.addr}, {1'b1, a2});
    next(); mid();
    chk({tag, "_idle"}, bus_if.bstart, 1'b0);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; halted = 1'b0;
    core_if.bstart = 1'b0; core_if.breq = 1'b0; core_if.ttype = READ;
    core_if.addr = '0; core_if.wdata = '0; core_if.tsize = WORD;
    dm_if.bstart = 1'b0; dm_if.breq = 1'b0; dm_if.ttype = READ;
    dm_if.addr = '0; dm_if.wdata = '0; dm_if.tsize = WORD;
    bus_if.bdone = 1'b0; bus_if.rdata = '0;

    repeat (2) next();
    mid();
    chk("rst_bus_ctl", {bus_if.bstart, bus_if.breq}, 2'b00);
    chk("rst_bus_type", {bus_if.ttype, bus_if.tsize}, {READ, WORD});
    chk("rst_bus_addr", bus_if.addr, 32'h0);
    chk("rst_req_done", {core_if.bdone, dm_if.bdone}, 2'b00);
    chk("rst_req_rdata", {core_if.rdata, dm_if.rdata}, 64'h0);
    chk("rst_perr", proto_err, 1'b0);
    next(); rst_n = 1'b1;

    // single core read, bus completes two cycles after launch
    next(); req(1'b0, 32'h1000, READ, 32'h0); mid();
    chk("rd_no_comb_launch", bus_if.bstart, 1'b0);
    next(); mid();
    chk("rd_launch", {bus_if.bstart, bus_if.breq, bus_if.addr}, {2'b11, 32'h1000});
    chk("rd_ttype", bus_if.ttype, READ);
    chk("rd_dm_done0", dm_if.bdone, 1'b0);
    next(); mid();
    chk("rd_pulse_once", bus_if.bstart, 1'b0);
    chk("rd_addr_stable", bus_if.addr, 32'h1000);
    chk("rd_wait_done0", core_if.bdone, 1'b0);
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'hDEADBEEF; mid();
    chk("rd_done", core_if.bdone, 1'b1);
    chk("rd_rdata", core_if.rdata, 32'hDEADBEEF);
    chk("rd_dm_done1", dm_if.bdone, 1'b0);
    next(); bus_if.rdata = 32'h0; mid();
    chk("rd_done_clr", core_if.bdone, 1'b0);
    chk("rd_rdata_hold", core_if.rdata, 32'hDEADBEEF);
    chk("rd_dm_rdata", dm_if.rdata, 32'h0);
    chk("rd_idle", dut.state, GIDLE);

    // fairness: first tie after reset goes to the DM
    next(); rst_n = 1'b0;
    next(); rst_n = 1'b1;
    tie(1'b1, "tie1");
    single(1'b1, 32'h3100, "dm_solo1");
    tie(1'b0, "tie2");

    // halted priority overrides a pointer that favours the core
    halted = 1'b1;
    tie(1'b1, "halt1");
    single(1'b1, 32'h3200, "dm_solo2");
    tie(1'b1, "halt2");
    halted = 1'b0;

    // DM write queued behind an in-flight core read
    next(); req(1'b0, 32'h4000, READ, 32'h0); mid();
    next(); req(1'b1, 32'h5000, WRITE, 32'h12345678); mid();
    chk("q_core_launch", {bus_if.bstart, bus_if.addr}, {1'b1, 32'h4000});
    next(); mid();
    chk("q_wait", {bus_if.bstart, bus_if.addr}, {1'b0, 32'h4000});
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'hCAFE; mid();
    chk("q_core_done", {core_if.bdone, dm_if.bdone}, 2'b10);
    next(); bus_if.rdata = 32'h0; mid();
    chk("q_dm_launch", {bus_if.bstart, bus_if.ttype, bus_if.addr}, {1'b1, WRITE, 32'h5000});
    chk("q_dm_wdata", bus_if.wdata, 32'h12345678);
    next(); bus_if.bdone = 1'b1; mid();
    chk("q_dm_done", {dm_if.bdone, core_if.bdone}, 2'b10);
    chk("q_wdata_stable", bus_if.wdata, 32'h12345678);
    chk("q_core_rdata_hold", core_if.rdata, 32'hCAFE);
    chk("q_perr", proto_err, 1'b0);

    // protocol error: core restarts while its read is in flight
    next(); req(1'b0, 32'h6000, READ, 32'h0); mid();
    next(); req(1'b0, 32'h7000, READ, 32'h0); mid();
    chk("pe_before", proto_err, 1'b0);
    chk("pe_launch", bus_if.addr, 32'h6000);
    next(); mid();
    chk("pe_set", proto_err, 1'b1);
    chk("pe_addr_kept", {bus_if.bstart, bus_if.addr}, {1'b0, 32'h6000});
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'h77; mid();
    chk("pe_done", core_if.bdone, 1'b1);
    next(); mid();
    chk("pe_no_replay1", {bus_if.bstart, dut.state}, {1'b0, GIDLE});
    next(); mid();
    chk("pe_no_replay2", bus_if.bstart, 1'b0);
    chk("pe_sticky", proto_err, 1'b1);

    // reset in the middle of a transaction
    next(); req(1'b0, 32'h8000, READ, 32'h0); mid();
    next(); mid();
    chk("ab_launch", {bus_if.bstart, bus_if.addr}, {1'b1, 32'h8000});
    next(); bus_if.bdone = 1'b1; bus_if.rdata = 32'hBAD; rst_n = 1'b0; mid();
    chk("ab_addr", bus_if.addr, 32'h0);
    chk("ab_bdone", core_if.bdone, 1'b0);
    chk("ab_rdata", core_if.rdata, 32'h0);
    chk("ab_perr", proto_err, 1'b0);
    chk("ab_state", dut.state, GIDLE);
    next(); rst_n = 1'b1; bus_if.bdone = 1'b1; mid();
    chk("ab_no_done1", core_if.bdone, 1'b0);
    next(); mid();
    chk("ab_no_done2", {bus_if.bstart, core_if.bdone}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
